mmio_timer_bank: RTL and testbench

Memory-mapped bank of NUM_TIMERS independent up-counting timers with reload. Each timer has a prescaler, auto-reload or one-shot mode, and a maskable, sticky, write-1-to-clear interrupt. Sits beside the MEM-stage peripheral decode. Supplies combinational read data and an address-hit flag to the MEM read mux, and per-channel plus combined interrupt lines to the CPU interrupt logic.

---
 rtl/mmio_timer_bank_if.sv | 22 ++
 rtl/mmio_timer_bank.sv | 151 +++++++++++++++
 tb/tb_mmio_timer_bank.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/mmio_timer_bank_if.sv
// rtl/mmio_timer_bank_if.sv - MEM-stage peripheral bus bundle for the timer bank
//
// Purpose: groups the store/load signals shared by the CPU MEM stage
// (master) and a memory-mapped peripheral (slave).
// Signals:
//   addr     byte address from the EX/MEM ALU result
//   wr_en    store strobe; the slave qualifies it with its own hit
//   wr_data  store data
//   rd_data  combinational read data from the slave (0 when not hit)
//   hit      slave claims addr
interface mmio_timer_bank_if;
   logic [31:0] addr;
   logic        wr_en;
   logic [31:0] wr_data;
   logic [31:0] rd_data;
   logic        hit;

   modport master (output addr, output wr_en, output wr_data,
                   input  rd_data, input hit);
   modport slave  (input  addr, input wr_en, input wr_data,
                   output rd_data, output hit);
endinterface

// File: rtl/mmio_timer_bank.sv
// rtl/mmio_timer_bank.sv - bank of prescaled up-counting timers with reload and irq
//
// Purpose: NUM_TIMERS independent timers. Each channel counts TL up on
// prescaler ticks; on TL == all ones it reloads from TH and sets a sticky
// pending flag (write-1-to-clear). One-shot mode clears en on overflow.
// Channel i sits at BASE_ADDR + 16*i: +0 TH, +4 TL, +8 TCON, +C PRESCALE.
// TCON bits: [0] en, [1] irq_en, [2] pending, [3] oneshot.
// Ports:
//   clk      system clock, rising edge
//   reset    synchronous, active-high
//   bus      slave side of the MEM-stage bus (addr/wr_en/wr_data in,
//            rd_data/hit out, combinational)
//   irq      per-channel pending & irq_en
//   irq_any  OR of irq
module mmio_timer_bank #(
   parameter int          NUM_TIMERS = 2,
   parameter int          WIDTH      = 32,
   parameter int          PRESCALE_W = 8,
   parameter logic [31:0] BASE_ADDR  = 32'h4000_0000
) (
   input  logic                  clk,
   input  logic                  reset,
   mmio_timer_bank_if.slave      bus,
   output logic [NUM_TIMERS-1:0] irq,
   output logic                  irq_any
);

   localparam logic [31:0] WINDOW = 32'(16 * NUM_TIMERS);

   logic [WIDTH-1:0]      th_q   [NUM_TIMERS];
   logic [WIDTH-1:0]      th_d   [NUM_TIMERS];
   logic [WIDTH-1:0]      tl_q   [NUM_TIMERS];
   logic [WIDTH-1:0]      tl_d   [NUM_TIMERS];
   logic [PRESCALE_W-1:0] ps_q   [NUM_TIMERS];
   logic [PRESCALE_W-1:0] ps_d   [NUM_TIMERS];
   logic [PRESCALE_W-1:0] pcnt_q [NUM_TIMERS];
   logic [PRESCALE_W-1:0] pcnt_d [NUM_TIMERS];
   logic [NUM_TIMERS-1:0] en_q, en_d;
   logic [NUM_TIMERS-1:0] irq_en_q, irq_en_d;
   logic [NUM_TIMERS-1:0] pend_q, pend_d;
   logic [NUM_TIMERS-1:0] os_q, os_d;

   logic [31:0] off;
   logic [1:0]  reg_sel;

   // Offset from the base; addresses below the base are rejected explicitly
   // because the subtraction wraps.
   assign off     = bus.addr - BASE_ADDR;
   assign reg_sel = bus.addr[3:2];
   assign bus.hit = (bus.addr[1:0] == 2'b00) && (bus.addr >= BASE_ADDR) && (off < WINDOW);

   always_comb begin
      bus.rd_data = '0;
      for (int i = 0; i < NUM_TIMERS; i++) begin
         if (bus.hit && (off[6:4] == 3'(i))) begin
            case (reg_sel)
               2'd0: bus.rd_data = 32'(th_q[i]);
               2'd1: bus.rd_data = 32'(tl_q[i]);
               2'd2: bus.rd_data = {28'd0, os_q[i], pend_q[i], irq_en_q[i], en_q[i]};
               default: bus.rd_data = 32'(ps_q[i]);
            endcase
         end
      end
   end

   always_comb begin
      en_d     = en_q;
      irq_en_d = irq_en_q;
      pend_d   = pend_q;
      os_d     = os_q;
      for (int i = 0; i < NUM_TIMERS; i++) begin
         logic tick;
         logic ovf;
         logic wsel;
         th_d[i]   = th_q[i];
         tl_d[i]   = tl_q[i];
         ps_d[i]   = ps_q[i];
         pcnt_d[i] = '0;
         tick      = 1'b0;
         ovf       = 1'b0;
         wsel      = bus.wr_en && bus.hit && (off[6:4] == 3'(i));

         if (en_q[i]) begin
            if (pcnt_q[i] == ps_q[i]) begin
               tick = 1'b1;
            end else begin
               pcnt_d[i] = pcnt_q[i] + PRESCALE_W'(1);
            end
         end

         if (tick) begin
            if (tl_q[i] == '1) begin
               ovf       = 1'b1;
               tl_d[i]   = th_q[i];   // reload always uses the pre-edge TH
               pend_d[i] = 1'b1;
               if (os_q[i]) en_d[i] = 1'b0;
            end else begin
               tl_d[i] = tl_q[i] + WIDTH'(1);
            end
         end

         // CPU writes are applied last so they override the count logic,
         // except that an overflow-set of pending beats a W1C.
         if (wsel) begin
            case (reg_sel)
               2'd0: th_d[i] = bus.wr_data[WIDTH-1:0];
               2'd1: tl_d[i] = bus.wr_data[WIDTH-1:0];
               2'd2: begin
                  en_d[i]     = bus.wr_data[0];
                  irq_en_d[i] = bus.wr_data[1];
                  os_d[i]     = bus.wr_data[3];
                  pend_d[i]   = (pend_q[i] & ~bus.wr_data[2]) | ovf;
                  // Restart the prescaler on enable; hold it at 0 on disable.
                  if (!en_q[i] || !bus.wr_data[0]) pcnt_d[i] = '0;
               end
               default: ps_d[i] = bus.wr_data[PRESCALE_W-1:0];
            endcase
         end
      end
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         en_q     <= '0;
         irq_en_q <= '0;
         pend_q   <= '0;
         os_q     <= '0;
         for (int i = 0; i < NUM_TIMERS; i++) begin
            th_q[i]   <= '0;
            tl_q[i]   <= '1;
            ps_q[i]   <= '0;
            pcnt_q[i] <= '0;
         end
      end else begin
         en_q     <= en_d;
         irq_en_q <= irq_en_d;
         pend_q   <= pend_d;
         os_q     <= os_d;
         for (int i = 0; i < NUM_TIMERS; i++) begin
            th_q[i]   <= th_d[i];
            tl_q[i]   <= tl_d[i];
            ps_q[i]   <= ps_d[i];
            pcnt_q[i] <= pcnt_d[i];
         end
      end
   end

   assign irq     = pend_q & irq_en_q;
   assign irq_any = |irq;

endmodule

// File: tb/tb_mmio_timer_bank.sv
// tb/tb_mmio_timer_bank.sv - self-checking bench for mmio_timer_bank
module tb_mmio_timer_bank;

   localparam logic [31:0] BASE = 32'h4000_0000;
   localparam logic [31:0] TH0 = BASE + 32'h00, TL0 = BASE + 32'h04;
   localparam logic [31:0] TC0 = BASE + 32'h08, PS0 = BASE + 32'h0C;
   localparam logic [31:0] TH1 = BASE + 32'h10, TL1 = BASE + 32'h14;
   localparam logic [31:0] TC1 = BASE + 32'h18, PS1 = BASE + 32'h1C;

   typedef struct {
      string       name;
      logic [31:0] addr;
      logic [31:0] rd;
      logic        hit;
   } rd_vec_t;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic [1:0] irq;
   logic       irq_any;
   int         total = 0;
   int         passed = 0;
   rd_vec_t    tab [13];

   mmio_timer_bank_if bus ();

   mmio_timer_bank #(
      .NUM_TIMERS(2), .WIDTH(32), .PRESCALE_W(8), .BASE_ADDR(BASE)
   ) dut (
      .clk(clk), .reset(reset), .bus(bus), .irq(irq), .irq_any(irq_any)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got === exp) passed++;
      else $display("FAIL %s: got %h expected %h", name, got, exp);
   endtask

   // Called at a negedge; the store commits on the following posedge.
   task automatic wr(input logic [31:0] a, input logic [31:0] d);
      bus.addr    = a;
      bus.wr_data = d;
      bus.wr_en   = 1'b1;
      @(negedge clk);
      bus.wr_en   = 1'b0;
   endtask

   task automatic chk_reg(input string name, input logic [31:0] a, input logic [31:0] exp);
      bus.addr = a;
      #1;
      check(name, bus.rd_data, exp);
   endtask

   task automatic run_table();
      for (int i = 0; i < 13; i++) begin
         bus.addr = tab[i].addr;
         #1;
         check({tab[i].name, "_rd"}, bus.rd_data, tab[i].rd);
         check({tab[i].name, "_hit"}, 32'(bus.hit), 32'(tab[i].hit));
      end
      check("irq_rst", 32'(irq), 32'd0);
      check("irq_any_rst", 32'(irq_any), 32'd0);
      @(negedge clk);
   endtask

   initial begin
      tab[0]  = '{"th0",  TH0, 32'h0, 1'b1};
      tab[1]  = '{"tl0",  TL0, 32'hFFFF_FFFF, 1'b1};
      tab[2]  = '{"tc0",  TC0, 32'h0, 1'b1};
      tab[3]  = '{"ps0",  PS0, 32'h0, 1'b1};
      tab[4]  = '{"th1",  TH1, 32'h0, 1'b1};
      tab[5]  = '{"tl1",  TL1, 32'hFFFF_FFFF, 1'b1};
      tab[6]  = '{"tc1",  TC1, 32'h0, 1'b1};
      tab[7]  = '{"ps1",  PS1, 32'h0, 1'b1};
      tab[8]  = '{"out_hi", BASE + 32'h20, 32'h0, 1'b0};
      tab[9]  = '{"misal2", BASE + 32'h02, 32'h0, 1'b0};
      tab[10] = '{"below",  BASE - 32'h4, 32'h0, 1'b0};
      tab[11] = '{"misal1e", BASE + 32'h1E, 32'h0, 1'b0};
      tab[12] = '{"ps1_edge", BASE + 32'h1C, 32'h0, 1'b1};

      bus.addr = '0; bus.wr_data = '0; bus.wr_en = 1'b0;
      repeat (2) @(negedge clk);
      reset = 1'b0;

      // Reset state and address decode.
      run_table();
      wr(BASE + 32'h20, 32'h1234_5678);
      wr(BASE + 32'h24, 32'h0000_0055);
      wr(BASE + 32'h02, 32'hDEAD_BEEF);
      wr(BASE + 32'h0A, 32'h0000_0003);
      run_table();

      // Ch0 auto-reload every cycle.
      wr(TH0, 32'hFFFF_FFFC);
      wr(TL0, 32'hFFFF_FFFC);
      wr(TC0, 32'h3);
      chk_reg("c0_tl_start", TL0, 32'hFFFF_FFFC);
      for (int k = 1; k <= 3; k++) begin
         @(negedge clk);
         chk_reg($sformatf("c0_tl_step%0d", k), TL0, 32'hFFFF_FFFC + 32'(k));
      end
      @(negedge clk);
      chk_reg("c0_tl_reload", TL0, 32'hFFFF_FFFC);
      chk_reg("c0_tcon_pend", TC0, 32'h7);
      check("c0_irq", 32'(irq), 32'h1);
      check("c0_irq_any", 32'(irq_any), 32'h1);
      wr(TC0, 32'h7);
      chk_reg("c0_tcon_clr", TC0, 32'h3);
      chk_reg("c0_tl_cont", TL0, 32'hFFFF_FFFD);
      check("c0_irq_clr", 32'(irq), 32'h0);
      wr(TC0, 32'h0);

      // Ch1 one-shot with prescale 3.
      wr(PS1, 32'h3);
      wr(TL1, 32'hFFFF_FFFE);
      wr(TC1, 32'hB);
      repeat (3) @(negedge clk);
      chk_reg("c1_tl_hold", TL1, 32'hFFFF_FFFE);
      @(negedge clk);
      chk_reg("c1_tl_tick1", TL1, 32'hFFFF_FFFF);
      repeat (4) @(negedge clk);
      chk_reg("c1_tl_reload", TL1, 32'h0);
      chk_reg("c1_tcon_os", TC1, 32'hE);
      check("c1_irq", 32'(irq), 32'h2);
      repeat (3) @(negedge clk);
      chk_reg("c1_tl_stopped", TL1, 32'h0);
      wr(TC1, 32'h4);
      chk_reg("c1_tcon_clr", TC1, 32'h0);
      check("c1_irq_clr", 32'(irq), 32'h0);

      // CPU en write beats one-shot auto-clear on the overflow edge.
      wr(PS1, 32'h0);
      wr(TL1, 32'hFFFF_FFFF);
      wr(TC1, 32'h9);
      wr(TC1, 32'h9);
      chk_reg("c1_en_wins", TC1, 32'hD);
      chk_reg("c1_tl_ovf", TL1, 32'h0);
      @(negedge clk);
      chk_reg("c1_tl_runs", TL1, 32'h1);
      wr(TC1, 32'h4);
      chk_reg("c1_tcon_off", TC1, 32'h0);

      // TL write beats tick on the same edge.
      wr(TH0, 32'h0);
      wr(TL0, 32'h100);
      wr(TC0, 32'h1);
      wr(TL0, 32'h10);
      chk_reg("c0_tl_wr_wins", TL0, 32'h10);
      @(negedge clk);
      chk_reg("c0_tl_after_wr", TL0, 32'h11);

      // Overflow set beats W1C; irq_en=0 masks irq.
      wr(TL0, 32'hFFFF_FFFE);
      @(negedge clk);
      wr(TC0, 32'h5);
      chk_reg("c0_set_wins", TC0, 32'h5);
      chk_reg("c0_tl_wrap", TL0, 32'h0);
      check("c0_irq_masked", 32'(irq), 32'h0);
      check("c0_irq_any_masked", 32'(irq_any), 32'h0);
      chk_reg("c1_untouched", TC1, 32'h0);
      wr(PS0, 32'h5);
      wr(TC0, 32'h3);
      check("c0_irq_unmask", 32'(irq), 32'h1);

      // Reset mid-count with pending set.
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      run_table();

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
